// File: rtl/i2c_target_responder_if.sv
// Open-drain I2C bus seen by the target: raw SCL/SDA from the pad and the SDA pull-down enable.
interface i2c_target_responder_if;
    logic SCL;
    logic SDA_in;
    logic SDA_LowEnable;

    modport master (output SCL, output SDA_in, input SDA_LowEnable);
    modport slave  (input SCL, input SDA_in, output SDA_LowEnable);
endinterface

// File: rtl/i2c_target_responder.sv
// TMP101-style I2C target: pointer, read-only temperature and R/W configuration register.
// Inputs see 2 cycles of sync latency; SDA updates 1 cycle after a synced SCL fall; never stretches SCL.
module i2c_target_responder #(
    parameter logic [6:0] ADDRESS      = 7'b1001000,
    parameter logic [7:0] CONFIG_RESET = 8'h00
) (
    input  logic                    CLOCK,
    input  logic                    Reset,
    i2c_target_responder_if.slave   bus,
    input  logic [11:0]             Temperature,
    output logic [7:0]              ConfigReg,
    output logic [1:0]              Pointer,
    output logic                    Busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    state_t      state;
    logic        sclMeta, sclSync, sclPrev;
    logic        sdaMeta, sdaSync, sdaPrev;
    logic [3:0]  bitCnt;
    logic [7:0]  rxShift;
    logic [7:0]  txShift;
    logic        readNotWrite;
    logic [1:0]  byteIdx;
    logic [3:0]  tempLow;
    logic        sdaLow;

    logic        sclRise, sclFall, startDet, stopDet;
    logic [7:0]  rxByte;
    logic [7:0]  txNext;

    assign sclRise  = sclSync & ~sclPrev;
    assign sclFall  = ~sclSync & sclPrev;
    assign startDet = sclSync & sdaPrev & ~sdaSync;
    assign stopDet  = sclSync & ~sdaPrev & sdaSync;
    assign rxByte   = {rxShift[6:0], sdaSync};

    assign bus.SDA_LowEnable = sdaLow;

    // The low nibble of an odd byte comes from the sample taken with the preceding even byte.
    always_comb begin
        txNext = ConfigReg;
        if (!Pointer[0]) begin
            txNext = byteIdx[0] ? {tempLow, 4'b0000} : Temperature[11:4];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            sclMeta      <= 1'b1;
            sclSync      <= 1'b1;
            sclPrev      <= 1'b1;
            sdaMeta      <= 1'b1;
            sdaSync      <= 1'b1;
            sdaPrev      <= 1'b1;
            state        <= IDLE;
            bitCnt       <= '0;
            rxShift      <= '0;
            txShift      <= '1;
            readNotWrite <= 1'b0;
            byteIdx      <= '0;
            tempLow      <= '0;
            sdaLow       <= 1'b0;
            ConfigReg    <= CONFIG_RESET;
            Pointer      <= '0;
            Busy         <= 1'b0;
        end else begin
            sclMeta <= bus.SCL;
            sclSync <= sclMeta;
            sclPrev <= sclSync;
            sdaMeta <= bus.SDA_in;
            sdaSync <= sdaMeta;
            sdaPrev <= sdaSync;

            if (stopDet) begin
                state  <= IDLE;
                sdaLow <= 1'b0;
                Busy   <= 1'b0;
            end else if (startDet) begin
                state  <= ADDR;
                bitCnt <= '0;
                sdaLow <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (sclRise) begin
                            rxShift <= rxByte;
                            if (bitCnt == 4'd7) begin
                                if (rxByte[7:1] == ADDRESS) begin
                                    Busy         <= 1'b1;
                                    readNotWrite <= rxByte[0];
                                    byteIdx      <= '0;
                                    bitCnt       <= 4'd8;
                                    state        <= ADDR_ACK;
                                end else begin
                                    Busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            end else begin
                                bitCnt <= bitCnt + 4'd1;
                            end
                        end
                    end

                    // bitCnt 8: waiting for the fall that starts the ACK; 9: ACK clock has risen.
                    ADDR_ACK, RX_ACK: begin
                        if (sclRise) begin
                            bitCnt <= 4'd9;
                        end else if (sclFall) begin
                            if (bitCnt == 4'd8) begin
                                sdaLow <= 1'b1;
                            end else begin
                                bitCnt <= '0;
                                if (state == ADDR_ACK && readNotWrite) begin
                                    txShift <= {txNext[6:0], 1'b1};
                                    sdaLow  <= ~txNext[7];
                                    if (!Pointer[0] && !byteIdx[0]) tempLow <= Temperature[3:0];
                                    state   <= TX_BYTE;
                                end else begin
                                    sdaLow <= 1'b0;
                                    if (state == RX_ACK && byteIdx != 2'd2) byteIdx <= byteIdx + 2'd1;
                                    state  <= RX_BYTE;
                                end
                            end
                        end
                    end

                    RX_BYTE: begin
                        if (sclRise) begin
                            rxShift <= rxByte;
                            if (bitCnt == 4'd7) begin
                                if (byteIdx == 2'd0)  Pointer   <= rxByte[1:0];
                                else if (Pointer[0])  ConfigReg <= rxByte;
                                bitCnt <= 4'd8;
                                state  <= RX_ACK;
                            end else begin
                                bitCnt <= bitCnt + 4'd1;
                            end
                        end
                    end

                    TX_BYTE: begin
                        if (sclRise) begin
                            bitCnt <= bitCnt + 4'd1;
                        end else if (sclFall) begin
                            if (bitCnt == 4'd8) begin
                                sdaLow <= 1'b0;
                                state  <= TX_ACK;
                            end else begin
                                sdaLow  <= ~txShift[7];
                                txShift <= {txShift[6:0], 1'b1};
                            end
                        end
                    end

                    TX_ACK: begin
                        if (sclRise) begin
                            if (sdaSync) begin
                                state <= WAIT_STOP;
                            end else begin
                                byteIdx <= {1'b0, ~byteIdx[0]};
                                bitCnt  <= 4'd9;
                            end
                        end else if (sclFall && bitCnt == 4'd9) begin
                            bitCnt  <= '0;
                            txShift <= {txNext[6:0], 1'b1};
                            sdaLow  <= ~txNext[7];
                            if (!Pointer[0] && !byteIdx[0]) tempLow <= Temperature[3:0];
                            state   <= TX_BYTE;
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- I2C target (slave) that answers the team's I2C master driver on the same SCL/SDA pair.
- Emulates the TMP101 register interface. Pointer register selects 0 = Temperature (read-only, 12-bit) or 1 = Configuration (8-bit, R/W).
- Used as the on-chip bench and loopback partner for the driver, and as a synthesizable sensor stand-in on the FPGA.
- SCL/SDA are oversampled by CLOCK; the block never drives SCL (no clock stretching).

Parameters:
- ADDRESS, 7'b1001000, 7-bit target address (TMP101 with ADD0 tied low).
- CONFIG_RESET, 8'h00, reset value of the Configuration register.

Ports:
- CLOCK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- SCL  input  1  raw I2C clock from the master.
- SDA_in  input  1  raw I2C data line as read from the pad.
- SDA_LowEnable  output  1  1 = pull SDA low (open-drain enable); 0 = release.
- Temperature  input  12  two's-complement temperature, 0.0625 °C/LSB; sampled at the start of each read byte.
- ConfigReg  output  8  current Configuration register.
- Pointer  output  2  current pointer register (only bit 0 decoded; bit 1 stored).
- Busy  output  1  1 from an address match until STOP or a non-match.

Behaviour:
- Reset values: SDA_LowEnable=0, ConfigReg=CONFIG_RESET, Pointer=0, Busy=0, state=IDLE.
- Reset mid-transfer: SDA is released on the next edge; all bus progress is discarded.
- Input sync: SCL and SDA_in each pass through 2 flops, plus 1 history flop for edge detection. Raw-to-internal latency is 2 cycles.
- Timing requirement on the master: SCL high ≥ 6 CLOCK cycles and SCL low ≥ 6 CLOCK cycles.
- START: synced SDA 1→0 while synced SCL=1. Valid in any state; repeated START included. Effect: bit counter=0, state=ADDR.
- STOP: synced SDA 0→1 while SCL=1. From any state: go to IDLE, release SDA, Busy=0.
- Sampling: received bits are taken on the synced SCL rising edge, MSB first.
- Driving: SDA_LowEnable changes only on the cycle after a synced SCL falling edge is detected.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits.
    - If bits[7:1]==ADDRESS: Busy=1, latch R/W, go to ADDR_ACK.
    - Otherwise: go to IDLE and ignore the bus until the next START.
  - ADDR_ACK: drive 0 for the 9th SCL period, released after its falling edge.
    - R/W=0: go to RX_BYTE, byte index=0.
    - R/W=1: go to TX_BYTE, byte index=0.
  - RX_BYTE: shift in 8 bits, then go to RX_ACK.
    - Byte index 0: Pointer ← byte[1:0].
    - Byte index ≥1 with Pointer[0]=1: ConfigReg ← byte.
    - Byte index ≥1 with Pointer[0]=0: byte is discarded but still ACKed.
  - RX_ACK: ACK for one SCL period; byte index++ (saturate at 2); back to RX_BYTE.
  - TX_BYTE: load the shift register at entry, then present one bit per SCL low phase.
    - Data bit 1 → release; data bit 0 → drive low.
    - Pointer 0, even byte index: Temperature[11:4].
    - Pointer 0, odd byte index: {Temperature[3:0],4'b0000}.
    - Pointer 1: ConfigReg every byte.
    - Temperature is captured at the load of an even-index byte, so the MSB/LSB pair is coherent.
  - TX_ACK: release SDA; sample the master bit on the 9th SCL rise.
    - 0 (ACK): index++, go to TX_BYTE.
    - 1 (NACK): go to WAIT_STOP (SDA released; only START/STOP are acted on).
- Byte index wraps mod 2 during reads. Pointer persists across transactions (TMP101 semantics).
- START and STOP have priority over bit processing when detected in the same cycle as an SCL edge.

Test Plan:
- Reset with CONFIG_RESET=8'h00 → SDA_LowEnable=0, ConfigReg=00, Pointer=0, Busy=0. Then a START with Reset held high → no response.
- Write 0x90, 0x01, 0x60, STOP → three ACKs (SDA low on each 9th clock), ConfigReg=8'h60, Pointer=1, Busy=0 after STOP.
- Write 0x90, 0x00, repeated START, 0x91, read 2 bytes (ACK, then NACK) with Temperature=12'h190 → target returns 0x19 then 0x00, and SDA is released after the NACK.
- Address 0x92 (0x49, W) → no ACK (SDA stays released on 9th clock), Busy stays 0, following bytes ignored until STOP; the next transaction to 0x90 ACKs normally.
- Read 0x91 with Pointer=1 and ConfigReg=60 across 3 bytes with master ACKs → 0x60, 0x60, 0x60. Change Temperature mid-read under Pointer=0 → MSB/LSB pair remains from the same sample.
- Assert Reset while the target drives a 0 data bit → SDA_LowEnable=0 next cycle, state IDLE; the next full write transaction succeeds.
